// File: rtl/reaction_ctrl_if.sv
// reaction_ctrl_if: buttons, timer flags and result qualifiers of the reaction-time controller
interface reaction_ctrl_if;
  logic btn_start, btn_react;
  logic signal_start, signal_overflow, signal_cleared;
  logic [2:0] machine_state;
  logic [13:0] rand_num;
  logic led_go, too_early, result_valid, timeout;
  modport master (
    input btn_start, btn_react, signal_start, signal_overflow, signal_cleared,
    output machine_state, rand_num, led_go, too_early, result_valid, timeout
  );
  modport slave (
    output btn_start, btn_react, signal_start, signal_overflow, signal_cleared,
    input machine_state, rand_num, led_go, too_early, result_valid, timeout
  );
endinterface

// File: rtl/reaction_ctrl.sv
// reaction_ctrl: debounced buttons, LFSR pre-start delay and round FSM of the reaction-time tester
module reaction_ctrl #(
  parameter logic [13:0] MIN_DELAY = 14'd1000,
  parameter int DEB_CYCLES = 16,
  parameter logic [11:0] LFSR_SEED = 12'hACE
) (
  input logic clk,
  input logic rst,
  reaction_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, WAIT = 3'd1, CLR_CNT1 = 3'd2, START = 3'd3,
    SHOW = 3'd4, CLR_CNT2 = 3'd5, EARLY = 3'd6, ILLEGAL = 3'd7
  } state_t;
  state_t st, nxt;
  logic [11:0] lfsr;
  logic [1:0] raw, press;
  assign raw = {bus.btn_react, bus.btn_start};
  // bit 0 = start button, bit 1 = react button
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic s1, s2, lvl, lvl_q;
    logic [7:0] cnt;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        {s1, s2, lvl, lvl_q} <= '0;
        cnt <= '0;
      end else begin
        {s2, s1} <= {s1, raw[i]};
        lvl_q <= lvl;
        cnt <= (s2 == lvl || cnt == 8'(DEB_CYCLES)) ? 8'd0 : cnt + 8'd1;
        if (s2 != lvl && cnt == 8'(DEB_CYCLES)) lvl <= s2;
      end
    assign press[i] = lvl & ~lvl_q;
  end
  always_comb begin
    nxt = st;
    case (st)
      IDLE, SHOW, EARLY: nxt = press[0] ? CLR_CNT2 : st;
      WAIT: nxt = press[1] ? EARLY : bus.signal_start ? CLR_CNT1 : WAIT;
      CLR_CNT1: nxt = bus.signal_cleared ? START : CLR_CNT1;
      START: nxt = (bus.signal_overflow || press[1]) ? SHOW : START;
      CLR_CNT2: nxt = bus.signal_cleared ? WAIT : CLR_CNT2;
      default: nxt = IDLE;
    endcase
  end
  assign bus.machine_state = st;
  // qualifiers are decoded from nxt so they line up with machine_state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      lfsr <= LFSR_SEED;
      bus.rand_num <= MIN_DELAY;
      bus.led_go <= 1'b0;
      bus.too_early <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      st <= nxt;
      lfsr <= {lfsr[10:0], lfsr[11] ^ lfsr[10] ^ lfsr[9] ^ lfsr[3]};
      if (nxt == CLR_CNT2 && st != CLR_CNT2) bus.rand_num <= MIN_DELAY + {2'b00, lfsr};
      bus.led_go <= nxt == START;
      bus.too_early <= nxt == EARLY;
      bus.result_valid <= nxt == SHOW;
      bus.timeout <= nxt == SHOW && (st == SHOW ? bus.timeout : bus.signal_overflow);
    end
endmodule
